barrel_shift_scheduler: RTL and testbench

//  Shares one BarrelShifter instance among NREQ requesters using round-robin arbitration.

---
 rtl/barrel_shift_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_barrel_shift_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_scheduler.sv
// -----------------------------------------------------------------------------
// barrel_shift_scheduler
//
// Shares a single left barrel shifter among NREQ requesters. A round-robin
// arbiter picks one pending requester per cycle. The winner's operand is
// shifted left by its amount, and the vacated low bits are filled with the
// winner's fill bit. The result is captured in a one-deep output register and
// returned on a valid/ready response channel, tagged with the winner's index.
//
// Shift function:
//   out = ({in, {WIDTH{fill}}} >> (WIDTH - amount))[WIDTH-1:0]
//   (in << amount, with the vacated low bits set to fill)
//
// Parameters
//   WIDTH  operand width; must be a power of two and at least 2
//   NREQ   number of requesters; at least 2
//
// Ports
//   Clock       in   1               single clock, all state on posedge
//   Reset       in   1               synchronous, active-high
//   ReqValid    in   NREQ            bit i: requester i has an operation pending
//   ReqIn       in   NREQ*WIDTH      operand of requester i at [i*WIDTH +: WIDTH]
//   ReqAmount   in   NREQ*AW         shift amount of requester i at [i*AW +: AW]
//   ReqShiftIn  in   NREQ            fill bit of requester i
//   ReqReady    out  NREQ            one-hot or zero; requester i accepted this edge
//   RespValid   out  1               result register holds a valid result
//   RespReady   in   1               consumer takes the result this edge
//   RespOut     out  WIDTH           shifted result
//   RespId      out  IDW             index of the requester that owns RespOut
// -----------------------------------------------------------------------------
module barrel_shift_scheduler #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                                Clock,
  input  logic                                Reset,
  input  logic [NREQ-1:0]                     ReqValid,
  input  logic [NREQ*WIDTH-1:0]               ReqIn,
  input  logic [NREQ*$clog2(WIDTH)-1:0]       ReqAmount,
  input  logic [NREQ-1:0]                     ReqShiftIn,
  output logic [NREQ-1:0]                     ReqReady,
  output logic                                RespValid,
  input  logic                                RespReady,
  output logic [WIDTH-1:0]                    RespOut,
  output logic [$clog2(NREQ)-1:0]             RespId
);

  localparam int AW  = $clog2(WIDTH);
  localparam int IDW = $clog2(NREQ);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $fatal(1, "barrel_shift_scheduler: WIDTH (%0d) must be a power of 2 >= 2", WIDTH);
  end

  if (NREQ < 2) begin : g_bad_nreq
    $fatal(1, "barrel_shift_scheduler: NREQ (%0d) must be >= 2", NREQ);
  end

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;

  // Index of the most recent winner; the search for the next winner starts
  // one position after it.
  logic [IDW-1:0]     last_grant;

  logic               grant_valid;
  logic [IDW-1:0]     grant_idx;
  logic               can_accept;
  logic               load;

  logic [WIDTH-1:0]   win_in;
  logic [AW-1:0]      win_amt;
  logic               win_fill;

  // stage[s] holds the operand after the first s amount bits have been
  // applied, so stage[AW] is the fully shifted result.
  logic [AW:0][WIDTH-1:0] stage;

  // ---------------------------------------------------------------------------
  // Round-robin grant: choose the first valid requester after last_grant,
  // wrapping around. The candidate index is formed by subtraction, not by a
  // modulo, so a non-power-of-two NREQ still maps to a simple comparator.
  // ---------------------------------------------------------------------------
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    // NOTE: every signal written in this always_comb gets a default before any
    // conditional code. Without the defaults, paths that skip an assignment
    // would infer latches.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_idx = IDW'(cand);
      if (!grant_valid && ReqValid[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Winner operand mux
  // ---------------------------------------------------------------------------
  always_comb begin
    win_in   = ReqIn[grant_idx*WIDTH +: WIDTH];
    win_amt  = ReqAmount[grant_idx*AW +: AW];
    win_fill = ReqShiftIn[grant_idx];
  end

  // ---------------------------------------------------------------------------
  // Shared log-depth left shifter. Stage s moves the data left by 2**s when
  // amount bit s is set, and fills the vacated low bits with the fill bit.
  // ---------------------------------------------------------------------------
  assign stage[0] = win_in;

  for (genvar s = 0; s < AW; s++) begin : g_stage
    localparam int STEP = 1 << s;
    assign stage[s+1] = win_amt[s] ? {stage[s][WIDTH-1-STEP:0], {STEP{win_fill}}}
                                   : stage[s];
  end

  // ---------------------------------------------------------------------------
  // Control FSM, next-state and outputs.
  // The register can take a new result when it is empty, or when its current
  // result leaves on this same edge. Reset blocks acceptance, so a grant never
  // appears to succeed on an edge whose result is thrown away.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    ReqReady   = '0;
    RespValid  = (state == FULL);
    can_accept = !Reset && ((state == EMPTY) || RespReady);
    load       = can_accept && grant_valid;

    if (load) begin
      ReqReady[grant_idx] = 1'b1;
      state_next          = FULL;
    end else if ((state == FULL) && RespReady) begin
      state_next = EMPTY;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    // NOTE: sequential state is updated with non-blocking assignments. Every
    // register then samples values from before the edge, whatever order the
    // blocks are evaluated in.
    if (Reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Result register and arbitration pointer. Without a load, the result holds,
  // including after it has been consumed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RespOut    <= '0;
      RespId     <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else if (load) begin
      RespOut    <= stage[AW];
      RespId     <= grant_idx;
      last_grant <= grant_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Interface properties
  // ---------------------------------------------------------------------------
  a_ready_onehot0 : assert property (@(posedge Clock) $onehot0(ReqReady))
    else $error("ReqReady is not one-hot or zero");

  a_resp_held : assert property (@(posedge Clock) disable iff (Reset)
    (RespValid && !RespReady) |=> (RespValid && $stable(RespOut) && $stable(RespId)))
    else $error("response changed while stalled");

  a_no_ready_in_reset : assert property (@(posedge Clock) Reset |-> (ReqReady == '0))
    else $error("ReqReady asserted during reset");

endmodule

// File: tb/tb_barrel_shift_scheduler.sv
// -----------------------------------------------------------------------------
// tb_barrel_shift_scheduler
//
// Self-checking bench for barrel_shift_scheduler. A reference model tracks
// the arbiter pointer and the output register occupancy. It predicts ReqReady
// each cycle. Each accepted operation pushes its expected result, computed
// from the shift formula, and its ID into a scoreboard queue. The head of the
// queue is compared against RespOut/RespId while a result is valid, and is
// popped when the result is consumed.
// -----------------------------------------------------------------------------
module tb_barrel_shift_scheduler;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int AW    = $clog2(WIDTH);
  localparam int IDW   = $clog2(NREQ);

  logic                  Clock = 1'b0;
  logic                  Reset;
  logic [NREQ-1:0]       ReqValid;
  logic [NREQ*WIDTH-1:0] ReqIn;
  logic [NREQ*AW-1:0]    ReqAmount;
  logic [NREQ-1:0]       ReqShiftIn;
  logic [NREQ-1:0]       ReqReady;
  logic                  RespValid;
  logic                  RespReady;
  logic [WIDTH-1:0]      RespOut;
  logic [IDW-1:0]        RespId;

  barrel_shift_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqIn      (ReqIn),
    .ReqAmount  (ReqAmount),
    .ReqShiftIn (ReqShiftIn),
    .ReqReady   (ReqReady),
    .RespValid  (RespValid),
    .RespReady  (RespReady),
    .RespOut    (RespOut),
    .RespId     (RespId)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [WIDTH-1:0] out;
    int               id;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_errors = 0;

  logic [WIDTH-1:0] in_a   [NREQ];
  logic [AW-1:0]    amt_a  [NREQ];
  logic             fill_a [NREQ];

  logic             exp_full;
  int               exp_last;
  int               last_winner;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference shift, written directly from the concatenate-and-shift formula.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] a,
                                                 input int amt, input logic f);
    logic [2*WIDTH-1:0] cat;
    cat = {a, {WIDTH{f}}};
    cat = cat >> (WIDTH - amt);
    return cat[WIDTH-1:0];
  endfunction

  // Reference arbiter: first valid index after last, wrapping; -1 if none.
  function automatic int model_grant(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic rand_req(input int i);
    in_a[i]   = WIDTH'($urandom);
    amt_a[i]  = AW'($urandom_range(0, WIDTH - 1));
    fill_a[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      ReqIn[i*WIDTH +: WIDTH] = in_a[i];
      ReqAmount[i*AW +: AW]   = amt_a[i];
      ReqShiftIn[i]           = fill_a[i];
    end
  endtask

  // One clock cycle, entered and left at a negedge. Inputs are driven, the
  // outputs are checked against the model just before the rising edge, and
  // then the model is advanced to match that edge.
  task automatic cycle();
    int              w;
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    drive();
    #1;
    exp_rdy = '0;
    w       = -1;
    if (!Reset && (!exp_full || RespReady)) begin
      w = model_grant(ReqValid, exp_last);
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    check("req_ready", 64'(ReqReady), 64'(exp_rdy));
    check("resp_valid", 64'(RespValid), 64'(exp_full));
    if (exp_full && sb.size() > 0) begin
      check("resp_out", 64'(RespOut), 64'(sb[0].out));
      check("resp_id", 64'(RespId), 64'(sb[0].id));
    end
    last_winner = w;
    if (Reset) begin
      exp_full = 1'b0;
      exp_last = NREQ - 1;
      sb.delete();
    end else begin
      if (exp_full && RespReady) begin
        void'(sb.pop_front());
        exp_full = 1'b0;
      end
      if (w >= 0) begin
        e.out    = ref_shift(in_a[w], int'(amt_a[w]), fill_a[w]);
        e.id     = w;
        sb.push_back(e);
        exp_last = w;
        exp_full = 1'b1;
      end
    end
    @(negedge Clock);
    // An accepted requester may present a fresh operation afterwards.
    if (w >= 0) rand_req(w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset     = 1'b1;
    ReqValid  = '1;
    RespReady = 1'b1;
    exp_full  = 1'b0;
    exp_last  = NREQ - 1;
    for (int i = 0; i < NREQ; i++) rand_req(i);
    drive();
    @(posedge Clock);
    @(negedge Clock);

    // 1. Reset with every request pending: no accepts, empty, zeroed result.
    repeat (2) cycle();
    check("rst_resp_out", 64'(RespOut), 64'h0);
    check("rst_resp_id", 64'(RespId), 64'h0);
    Reset = 1'b0;
    drive();
    #1;
    check("first_grant", 64'(ReqReady), 64'h1);
    cycle();
    ReqValid = '0;
    cycle();

    // 2. Single requester 2: 0x00F1 << 4 with fill 1.
    in_a[2] = 16'h00F1; amt_a[2] = 4'd4; fill_a[2] = 1'b1;
    ReqValid = 4'b0100;
    cycle();
    ReqValid = '0;
    #1;
    check("t2_valid", 64'(RespValid), 64'h1);
    check("t2_out", 64'(RespOut), 64'h0F1F);
    check("t2_id", 64'(RespId), 64'h2);
    cycle();

    // 3. Everyone pending, consumer always ready: one result per cycle.
    ReqValid = '1;
    repeat (12) cycle();

    // 4. Backpressure for five cycles, with one requester withdrawing, then
    //    a drain and refill on the same edge.
    RespReady = 1'b0;
    repeat (2) cycle();
    ReqValid[3] = 1'b0;
    repeat (3) cycle();
    RespReady = 1'b1;
    cycle();
    ReqValid = '1;
    repeat (3) cycle();
    ReqValid = '0;
    cycle();

    // 5. Amount WIDTH-1 with both fill values, then amount 0.
    in_a[1] = 16'h8001; amt_a[1] = 4'd15; fill_a[1] = 1'b0;
    ReqValid = 4'b0010;
    cycle();
    ReqValid = '0;
    #1;
    check("t5_fill0", 64'(RespOut), 64'h8000);
    in_a[1] = 16'h8001; amt_a[1] = 4'd15; fill_a[1] = 1'b1;
    ReqValid = 4'b0010;
    cycle();
    ReqValid = '0;
    #1;
    check("t5_fill1", 64'(RespOut), 64'hFFFF);
    in_a[3] = 16'hA5C3; amt_a[3] = 4'd0; fill_a[3] = 1'b1;
    ReqValid = 4'b1000;
    cycle();
    ReqValid = '0;
    #1;
    check("t5_amt0", 64'(RespOut), 64'hA5C3);
    cycle();

    // 6. Reset while full and stalled: result discarded, priority back to 0.
    ReqValid = 4'b0100;
    cycle();
    RespReady = 1'b0;
    ReqValid  = '1;
    repeat (2) cycle();
    Reset = 1'b1;
    cycle();
    Reset     = 1'b0;
    RespReady = 1'b1;
    drive();
    #1;
    check("t6_valid_after_reset", 64'(RespValid), 64'h0);
    check("t6_grant_after_reset", 64'(ReqReady), 64'h1);
    cycle();

    // Random traffic on both channels.
    for (int n = 0; n < 60; n++) begin
      ReqValid  = NREQ'($urandom);
      RespReady = 1'($urandom_range(0, 3) != 0);
      cycle();
    end

    ReqValid  = '0;
    RespReady = 1'b1;
    repeat (2) cycle();
    check("sb_empty", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
